// File: rtl/shift_ctr_multi_if.sv
// Control/status bundle for shift_ctr_multi: step controls and load value in,
// counter state and one-cycle status pulses out.
interface shift_ctr_multi_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             err;

    modport master (
        output en, dir, mode, load, load_val,
        input  out, wrap, err
    );

    modport slave (
        input  en, dir, mode, load, load_val,
        output out, wrap, err
    );
endinterface

// File: rtl/shift_ctr_multi.sv
// WIDTH-bit shift counter with runtime ring/Johnson selection, direction, load,
// illegal-state correction back to HOME, and registered wrap/err pulses.
module shift_ctr_multi #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_ctr_multi_if.slave  bus
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] HOME = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [CW-1:0]    ones;
    logic [CW-1:0]    trans;
    logic             state_legal;
    logic [WIDTH-1:0] shifted;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // Ring needs exactly one set bit; Johnson allows at most one adjacent-bit change.
    always_comb begin
        ones  = '0;
        trans = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(out_q[i]);
        end
        for (int i = 1; i < WIDTH; i++) begin
            trans = trans + CW'(out_q[i] ^ out_q[i-1]);
        end
        state_legal = (mode == MODE_RING) ? (ones == CW'(1)) : (trans <= CW'(1));
    end

    always_comb begin
        shifted = out_q;
        unique case ({mode, bus.dir})
            {MODE_RING,    1'b0}: shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            {MODE_RING,    1'b1}: shifted = {out_q[0], out_q[WIDTH-1:1]};
            {MODE_JOHNSON, 1'b0}: shifted = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            {MODE_JOHNSON, 1'b1}: shifted = {~out_q[0], out_q[WIDTH-1:1]};
            default:              shifted = out_q;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (bus.load) begin
            out_d = bus.load_val;
        end else if (bus.en) begin
            if (!state_legal) begin
                out_d = HOME;
                err_d = 1'b1;
            end else begin
                out_d  = shifted;
                wrap_d = (shifted == HOME);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= HOME;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_shift_ctr_multi.sv
// Scoreboard bench for shift_ctr_multi: directed sequences with literal
// expectations, then randomized stimulus checked against an independent model.
module tb_shift_ctr_multi;

    localparam int              W    = 4;
    localparam logic [W-1:0]    HOME = 4'b0001;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic         wrap;
        logic         err;
    } exp_t;

    logic clk;
    logic rst;
    shift_ctr_multi_if #(.WIDTH(W)) bus ();

    shift_ctr_multi #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] m_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one expectation just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".out"},  32'(bus.out),  32'(e.out));
            check({e.tag, ".wrap"}, 32'(bus.wrap), 32'(e.wrap));
            check({e.tag, ".err"},  32'(bus.err),  32'(e.err));
        end
    end

    task automatic apply(input logic r, input logic e, input logic d, input logic m,
                         input logic l, input logic [W-1:0] lv);
        rst          = r;
        bus.en       = e;
        bus.dir      = d;
        bus.mode     = m;
        bus.load     = l;
        bus.load_val = lv;
    endtask

    task automatic dstep(input string tag, input logic r, input logic e, input logic d,
                         input logic m, input logic l, input logic [W-1:0] lv,
                         input logic [W-1:0] eo, input logic ew, input logic ee);
        exp_t x;
        apply(r, e, d, m, l, lv);
        x.tag = tag; x.out = eo; x.wrap = ew; x.err = ee;
        sb.push_back(x);
        @(negedge clk);
    endtask

    function automatic logic legal_ring(input logic [W-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic legal_johnson(input logic [W-1:0] v);
        logic [W-1:0] pat;
        for (int k = 0; k <= W; k++) begin
            pat = W'((33'd1 << k) - 33'd1);
            if (v == pat || v == ~pat) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] model_next(input logic [W-1:0] v, input logic d,
                                                input logic m);
        logic [W-1:0] t;
        if (!d) begin
            t    = v << 1;
            t[0] = m ? ~v[W-1] : v[W-1];
        end else begin
            t      = v >> 1;
            t[W-1] = m ? ~v[0] : v[0];
        end
        return t;
    endfunction

    task automatic rstep();
        logic         r, e, d, m, l;
        logic [W-1:0] lv, n;
        exp_t         x;
        r  = ($urandom_range(0, 99) < 3);
        l  = ($urandom_range(0, 99) < 8);
        e  = ($urandom_range(0, 99) < 80);
        d  = 1'($urandom);
        m  = 1'($urandom);
        lv = W'($urandom);
        x.tag = "rand"; x.wrap = 1'b0; x.err = 1'b0;
        if (r) begin
            m_out = HOME;
        end else if (l) begin
            m_out = lv;
        end else if (e) begin
            if (!(m ? legal_johnson(m_out) : legal_ring(m_out))) begin
                m_out = HOME;
                x.err = 1'b1;
            end else begin
                n      = model_next(m_out, d, m);
                x.wrap = (n == HOME);
                m_out  = n;
            end
        end
        x.out = m_out;
        apply(r, e, d, m, l, lv);
        sb.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);

        // tag          rst  en   dir  mode load  lv       out      wrap err
        dstep("rst0",   1,   0,   0,   0,   0,    4'h0,    4'b0001, 0,   0);
        dstep("rst1",   1,   0,   0,   0,   0,    4'h0,    4'b0001, 0,   0);
        dstep("ring_u1", 0,  1,   0,   0,   0,    4'h0,    4'b0010, 0,   0);
        dstep("ring_u2", 0,  1,   0,   0,   0,    4'h0,    4'b0100, 0,   0);
        dstep("ring_u3", 0,  1,   0,   0,   0,    4'h0,    4'b1000, 0,   0);
        dstep("ring_u4", 0,  1,   0,   0,   0,    4'h0,    4'b0001, 1,   0);
        dstep("ring_u5", 0,  1,   0,   0,   0,    4'h0,    4'b0010, 0,   0);
        dstep("ring_u6", 0,  1,   0,   0,   0,    4'h0,    4'b0100, 0,   0);

        dstep("ld_home", 0,  1,   0,   1,   1,    4'b0001, 4'b0001, 0,   0);
        dstep("john_u1", 0,  1,   0,   1,   0,    4'h0,    4'b0011, 0,   0);
        dstep("john_u2", 0,  1,   0,   1,   0,    4'h0,    4'b0111, 0,   0);
        dstep("john_u3", 0,  1,   0,   1,   0,    4'h0,    4'b1111, 0,   0);
        dstep("john_u4", 0,  1,   0,   1,   0,    4'h0,    4'b1110, 0,   0);
        dstep("john_u5", 0,  1,   0,   1,   0,    4'h0,    4'b1100, 0,   0);
        dstep("john_u6", 0,  1,   0,   1,   0,    4'h0,    4'b1000, 0,   0);
        dstep("john_u7", 0,  1,   0,   1,   0,    4'h0,    4'b0000, 0,   0);
        dstep("john_u8", 0,  1,   0,   1,   0,    4'h0,    4'b0001, 1,   0);

        dstep("ring_d1", 0,  1,   1,   0,   0,    4'h0,    4'b1000, 0,   0);
        dstep("ring_d2", 0,  1,   1,   0,   0,    4'h0,    4'b0100, 0,   0);
        dstep("hold1",   0,  0,   1,   0,   0,    4'h0,    4'b0100, 0,   0);
        dstep("hold2",   0,  0,   0,   1,   0,    4'h0,    4'b0100, 0,   0);
        dstep("hold3",   0,  0,   1,   0,   0,    4'h0,    4'b0100, 0,   0);
        dstep("ring_d3", 0,  1,   1,   0,   0,    4'h0,    4'b0010, 0,   0);
        dstep("ring_d4", 0,  1,   1,   0,   0,    4'h0,    4'b0001, 1,   0);

        dstep("ld_bad",  0,  1,   0,   0,   1,    4'b0110, 4'b0110, 0,   0);
        dstep("fix_bad", 0,  1,   0,   0,   0,    4'h0,    4'b0001, 0,   1);
        dstep("resume1", 0,  1,   0,   0,   0,    4'h0,    4'b0010, 0,   0);
        dstep("sw_ill",  0,  1,   0,   1,   0,    4'h0,    4'b0001, 0,   1);
        dstep("sw_ok",   0,  1,   0,   1,   0,    4'h0,    4'b0011, 0,   0);
        dstep("ld_all1", 0,  0,   0,   1,   1,    4'b1111, 4'b1111, 0,   0);
        dstep("j2r_ill", 0,  1,   0,   0,   0,    4'h0,    4'b0001, 0,   1);

        dstep("jd_home", 0,  1,   1,   1,   0,    4'h0,    4'b0000, 0,   0);
        dstep("jd_2",    0,  1,   1,   1,   0,    4'h0,    4'b1000, 0,   0);
        dstep("jd_3",    0,  1,   1,   1,   0,    4'h0,    4'b1100, 0,   0);

        dstep("ld_0100", 0,  0,   0,   0,   1,    4'b0100, 4'b0100, 0,   0);
        dstep("rst_mid", 1,  1,   0,   0,   1,    4'b1010, 4'b0001, 0,   0);

        m_out = HOME;
        for (int i = 0; i < 300; i++) begin
            rstep();
        end

        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_ctr_multi.md
Name: shift_ctr_multi

Overview:
- Parametrised successor to the single-mode straight ring counter.
- WIDTH-bit shift counter, runtime-selectable ring (one-hot) or Johnson (twisted-ring) sequence.
- Adds direction control, enable, parallel load, illegal-state self-correction, and wrap/error status pulses.
- Used as a sequencer/phase generator; the standard bench drives it with a free-running clock and a short reset.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32. Ring period is WIDTH; Johnson period is 2*WIDTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance one step per clock when high
dir  input  1  0 = shift up (toward MSB), 1 = shift down (toward LSB)
mode  input  1  0 = ring, 1 = Johnson; sampled on every enabled step
load  input  1  parallel load request
load_val  input  WIDTH  value written on load
out  output  WIDTH  counter state (registered)
wrap  output  1  one-cycle pulse: a normal step just returned to HOME
err  output  1  one-cycle pulse: an illegal state was just corrected

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high on rst.
- HOME = {WIDTH-1 zeros, 1}. HOME is legal in both modes.
- Reset:
  - rst=1 at a clk edge sets out=HOME, wrap=0, err=0.
  - rst overrides load and en; reset mid-sequence takes effect at that edge.
- Priority per edge: rst > load > en. With en=0 and load=0, out holds and wrap=err=0.
- Load:
  - load=1 gives out<=load_val on the next edge, regardless of en.
  - Loaded value is not checked; wrap=err=0 on a load cycle.
- Ring legality: exactly one bit set.
- Johnson legality: at most one adjacent-bit transition across out[WIDTH-1:0], non-circular, i.e. 0..01..1 or 1..10..0; includes all-0 and all-1.
- Enabled step (en=1, load=0, rst=0), evaluated against the current mode:
  - If out is illegal: out<=HOME, err=1, wrap=0.
  - Ring up: out<={out[W-2:0],out[W-1]}. Ring down: out<={out[0],out[W-1:1]}.
  - Johnson up: out<={out[W-2:0],~out[W-1]}. Johnson down: out<={~out[0],out[W-1:1]}.
  - wrap=1 iff the shifted result equals HOME; err=0.
- wrap and err are registered and valid in the same cycle as the out value they describe; never both high.
- Mode or dir may change on any cycle and take effect on the next enabled step. A state legal in the old mode but illegal in the new mode is corrected at that step (err pulse).
- Timing: no latency beyond one register stage; a new state every enabled cycle, no bubbles.
- Up and down sequences are exact inverses; Johnson down from HOME goes to all-0.

Test Plan:
- WIDTH=4, rst 2 cycles, mode=0, dir=0, en=1 for 6 cycles:
  - out = 0010, 0100, 1000, 0001, 0010, 0100.
  - wrap=1 only with the 4th value (0001); err=0 throughout.
- mode=1, dir=0, en=1 from HOME for 8 cycles:
  - out = 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
  - wrap=1 only on the 8th cycle.
- Direction:
  - mode=0, dir=1 from HOME: out = 1000, 0100, 0010, 0001, with wrap on 0001.
  - en=0 for 3 cycles mid-sequence: out holds, wrap=0.
- Load and correction:
  - load=1, load_val=0110, en=1, mode=0: next out=0110, err=0.
  - Next enabled cycle: out=0001, err=1, wrap=0.
  - Then normal ring stepping resumes from 0001.
- Mode switch:
  - Ring at 0010, set mode=1 with en=1: out=0001, err=1.
  - Ring at 0001, switch to mode=1: out=0011, err=0.
- Reset mid-operation: rst=1 with load=1, load_val=1010, en=1 at out=0100 -> out=0001, wrap=0, err=0 next cycle.
